// File: rtl/rs_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_cmd_pkg
//  Description : Shared types and constants for the rs flip-flop command
//                stage: arbitration FSM state encoding, default debounce
//                length and command-counter width, and a helper that sizes
//                the debounce counter.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_cmd_pkg;

   // Default number of consecutive stable cycles before a debounced level moves
   localparam int unsigned c_debounce_cycles_dflt = 4;

   // Default width of the issued-command counter
   localparam int unsigned c_cnt_w_dflt = 8;

   // Arbitration FSM states
   typedef enum logic [0:0] {
      IDLE         = 1'b0,
      WAIT_RELEASE = 1'b1
   } state_t;

   // Width of a counter that must be able to hold the value 'cycles'
   function automatic int unsigned db_cnt_w(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage : rs_cmd_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser followed by a stable-level counter for
//                one raw push-button. The debounced level only changes once
//                the synchronised input has disagreed with it for
//                DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle
//                restarts the count.
//  Ports       : clk    - system clock, rising edge
//                rst    - asynchronous active-high reset
//                btn_in - raw button, asynchronous to clk
//                db_out - debounced, synchronous button level
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce
   import rs_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_dflt
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic db_out
);

   localparam int unsigned      c_cw   = db_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [c_cw-1:0]  c_last = c_cw'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_cw-1:0]  c_one  = c_cw'(1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_db;
   logic [c_cw-1:0] r_cnt;

   // r_sync1 may go metastable; only r_sync2 is used by the logic below
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else if (r_sync2 == r_db) begin
         r_cnt <= '0;
      end else if (r_cnt == c_last) begin
         // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample
         r_db  <= r_sync2;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_one;
      end
   end

   assign db_out = r_db;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/rs_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rs_cmd_gen
//  Description : Command stage in front of the rs flip-flop. Debounces the
//                set and reset buttons, detects presses, and arbitrates them
//                into single-cycle, mutually exclusive s / r pulses. A press
//                that arrives together with, or while, the other button is
//                active is rejected with a one-cycle conflict flag. After any
//                press the FSM ignores further presses until both buttons
//                are released.
//  Ports       : clk       - system clock, rising edge
//                rst       - asynchronous active-high reset
//                btn_set   - raw set button (asynchronous)
//                btn_reset - raw reset button (asynchronous)
//                s         - set command pulse
//                r         - reset command pulse
//                conflict  - one-cycle flag, press rejected
//                cmd_count - number of s/r pulses issued, wraps
//  Revision    : 1.0  initial release
// ============================================================================
module rs_cmd_gen
   import rs_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_dflt,
   parameter int unsigned CNT_W           = c_cnt_w_dflt
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_set,
   input  logic             btn_reset,
   output logic             s,
   output logic             r,
   output logic             conflict,
   output logic [CNT_W-1:0] cmd_count
);

   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic             w_db_set;
   logic             w_db_reset;
   logic             r_prev_set;
   logic             r_prev_reset;
   logic             w_rise_set;
   logic             w_rise_reset;
   state_t           r_state;
   logic             r_s;
   logic             r_r;
   logic             r_conflict;
   logic [CNT_W-1:0] r_cmd_count;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_set (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_set),
      .db_out (w_db_set)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_reset (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_reset),
      .db_out (w_db_reset)
   );

   assign w_rise_set   = w_db_set   & ~r_prev_set;
   assign w_rise_reset = w_db_reset & ~r_prev_reset;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev_set   <= 1'b0;
         r_prev_reset <= 1'b0;
         r_state      <= IDLE;
         r_s          <= 1'b0;
         r_r          <= 1'b0;
         r_conflict   <= 1'b0;
         r_cmd_count  <= '0;
      end else begin
         r_prev_set   <= w_db_set;
         r_prev_reset <= w_db_reset;
         r_s          <= 1'b0;
         r_r          <= 1'b0;
         r_conflict   <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_rise_set && w_rise_reset) begin
                  r_conflict <= 1'b1;
                  r_state    <= WAIT_RELEASE;
               end else if (w_rise_set) begin
                  // The other button already held down means an ambiguous request
                  if (w_db_reset) begin
                     r_conflict <= 1'b1;
                  end else begin
                     r_s         <= 1'b1;
                     r_cmd_count <= r_cmd_count + c_cnt_one;
                  end
                  r_state <= WAIT_RELEASE;
               end else if (w_rise_reset) begin
                  if (w_db_set) begin
                     r_conflict <= 1'b1;
                  end else begin
                     r_r         <= 1'b1;
                     r_cmd_count <= r_cmd_count + c_cnt_one;
                  end
                  r_state <= WAIT_RELEASE;
               end
            end

            WAIT_RELEASE: begin
               // Presses are swallowed here; this is what makes a press
               // yield exactly one pulse however long it is held
               if (!w_db_set && !w_db_reset) begin
                  r_state <= IDLE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign s         = r_s;
   assign r         = r_r;
   assign conflict  = r_conflict;
   assign cmd_count = r_cmd_count;

endmodule : rs_cmd_gen
`default_nettype wire

// File: tb/tb_rs_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_cmd_gen
//  Description : Self-checking bench for rs_cmd_gen. A behavioural model
//                follows raw button samples and predicts s, r, conflict and
//                cmd_count every cycle; directed sequences add literal
//                expectations for latency, pulse counts and reset behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_cmd_gen;

   localparam int D  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_set = 1'b0;
   logic          btn_reset = 1'b0;
   logic          s;
   logic          r;
   logic          conflict;
   logic [CW-1:0] cmd_count;

   int errors = 0;
   int checks = 0;

   rs_cmd_gen #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_set   (btn_set),
      .btn_reset (btn_reset),
      .s         (s),
      .r         (r),
      .conflict  (conflict),
      .cmd_count (cmd_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model. A button's debounced level flips once the level it
   // held two clock samples earlier (the synchroniser delay) has disagreed
   // with the debounced level for D consecutive cycles. A press is a
   // debounced rise; it is honoured only while both buttons were released
   // since the previous press.
   // ---------------------------------------------------------------------
   bit          hs[$];
   bit          hr[$];
   bit          m_db_s, m_db_r, m_prev_s, m_prev_r, m_armed;
   bit          e_s, e_r, e_c;
   int unsigned e_cnt;

   function automatic bit settled(input bit q[$], input bit db);
      for (int i = 0; i < D; i++) begin
         int idx;
         bit v;
         idx = q.size() - 2 - i;
         v   = (idx >= 0) ? q[idx] : 1'b0;
         if (v == db) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      bit rs, rr;
      if (rst) begin
         hs.delete();
         hr.delete();
         m_db_s = 0; m_db_r = 0; m_prev_s = 0; m_prev_r = 0; m_armed = 1;
         e_s = 0; e_r = 0; e_c = 0; e_cnt = 0;
      end else begin
         rs  = m_db_s & ~m_prev_s;
         rr  = m_db_r & ~m_prev_r;
         e_s = 0; e_r = 0; e_c = 0;
         if (m_armed) begin
            if (rs || rr) begin
               m_armed = 0;
               if ((rs && rr) || (rs && m_db_r) || (rr && m_db_s)) begin
                  e_c = 1;
               end else begin
                  e_s   = rs;
                  e_r   = rr;
                  e_cnt = (e_cnt + 1) % (1 << CW);
               end
            end
         end else if (!m_db_s && !m_db_r) begin
            m_armed = 1;
         end
         m_prev_s = m_db_s;
         m_prev_r = m_db_r;
         if (settled(hs, m_db_s)) m_db_s = ~m_db_s;
         if (settled(hr, m_db_r)) m_db_r = ~m_db_r;
         hs.push_back(btn_set);
         hr.push_back(btn_reset);
         if (hs.size() > D + 2) void'(hs.pop_front());
         if (hr.size() > D + 2) void'(hr.pop_front());
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_s", int'(s), int'(e_s));
         chk("model_r", int'(r), int'(e_r));
         chk("model_conflict", int'(conflict), int'(e_c));
         chk("model_cmd_count", int'(cmd_count), int'(e_cnt));
         chk("s_r_overlap", int'(s & r), 0);
         chk("one_hot_outputs", int'(s) + int'(r) + int'(conflict) > 1 ? 1 : 0, 0);
      end
   end

   // ---------------------------------------------------------------------
   // Directed observation helpers
   // ---------------------------------------------------------------------
   int obs_s, obs_r, obs_c, first_s, first_r, first_c;

   task automatic clear_obs();
      obs_s = 0; obs_r = 0; obs_c = 0;
      first_s = 0; first_r = 0; first_c = 0;
   endtask

   // Advance n cycles, sampling just after each falling edge; the index of
   // the first sample showing a pulse is kept (1 = first edge after drive).
   task automatic step_obs(input int n);
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         #1;
         if (s)        begin obs_s++; if (first_s == 0) first_s = i; end
         if (r)        begin obs_r++; if (first_r == 0) first_r = i; end
         if (conflict) begin obs_c++; if (first_c == 0) first_c = i; end
      end
   endtask

   initial begin
      clear_obs();
      step_obs(3);
      chk("reset_s", int'(s), 0);
      chk("reset_r", int'(r), 0);
      chk("reset_conflict", int'(conflict), 0);
      chk("reset_cmd_count", int'(cmd_count), 0);
      rst = 1'b0;
      step_obs(4);

      // Short press, shorter than the debounce window
      clear_obs();
      btn_set = 1'b1;
      step_obs(3);
      btn_set = 1'b0;
      step_obs(15);
      chk("glitch_pulses", obs_s + obs_r + obs_c, 0);
      chk("glitch_cmd_count", int'(cmd_count), 0);

      // Clean long set press
      clear_obs();
      btn_set = 1'b1;
      step_obs(20);
      chk("set_latency", first_s, 7);
      chk("set_pulse_count", obs_s, 1);
      chk("set_no_r", obs_r + obs_c, 0);
      chk("set_cmd_count", int'(cmd_count), 1);
      btn_set = 1'b0;
      step_obs(10);

      // Simultaneous press -> conflict, then a lone reset press
      clear_obs();
      btn_set   = 1'b1;
      btn_reset = 1'b1;
      step_obs(10);
      chk("both_conflict_latency", first_c, 7);
      chk("both_conflict_count", obs_c, 1);
      chk("both_no_sr", obs_s + obs_r, 0);
      chk("both_cmd_count", int'(cmd_count), 1);
      btn_set   = 1'b0;
      btn_reset = 1'b0;
      step_obs(10);
      clear_obs();
      btn_reset = 1'b1;
      step_obs(12);
      chk("reset_press_latency", first_r, 7);
      chk("reset_press_count", obs_r, 1);
      chk("reset_press_cmd_count", int'(cmd_count), 2);
      btn_reset = 1'b0;
      step_obs(10);

      // Second button pressed while first is held is swallowed
      clear_obs();
      btn_set = 1'b1;
      step_obs(10);
      chk("held_set_pulse", obs_s, 1);
      clear_obs();
      btn_reset = 1'b1;
      step_obs(15);
      chk("held_second_ignored", obs_r + obs_c + obs_s, 0);
      btn_reset = 1'b0;
      step_obs(10);
      // Release glitch on the held set button must not rearm the FSM
      btn_set = 1'b0;
      step_obs(2);
      btn_set = 1'b1;
      clear_obs();
      btn_reset = 1'b1;
      step_obs(12);
      chk("release_glitch_ignored", obs_r + obs_c + obs_s, 0);
      chk("release_glitch_cmd_count", int'(cmd_count), 3);
      btn_set   = 1'b0;
      btn_reset = 1'b0;
      step_obs(10);
      clear_obs();
      btn_reset = 1'b1;
      step_obs(12);
      chk("rearmed_reset_latency", first_r, 7);
      chk("rearmed_cmd_count", int'(cmd_count), 4);
      btn_reset = 1'b0;
      step_obs(10);

      // Asynchronous reset while a pulse is on the outputs
      clear_obs();
      btn_set = 1'b1;
      step_obs(7);
      chk("pre_rst_s_high", int'(s), 1);
      chk("pre_rst_cmd_count", int'(cmd_count), 5);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_s", int'(s), 0);
      chk("async_rst_cmd_count", int'(cmd_count), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      clear_obs();
      step_obs(12);
      chk("post_rst_latency", first_s, 7);
      chk("post_rst_pulses", obs_s, 1);
      chk("post_rst_cmd_count", int'(cmd_count), 1);
      btn_set = 1'b0;
      step_obs(10);

      // 256 alternating presses wrap the counter back to zero
      rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      clear_obs();
      for (int k = 0; k < 256; k++) begin
         if (k % 2 == 0) btn_set   = 1'b1;
         else            btn_reset = 1'b1;
         step_obs(8);
         btn_set   = 1'b0;
         btn_reset = 1'b0;
         step_obs(8);
         if (k == 127) chk("wrap_half_count", int'(cmd_count), 128);
      end
      chk("wrap_cmd_count", int'(cmd_count), 0);
      chk("wrap_s_pulses", obs_s, 128);
      chk("wrap_r_pulses", obs_r, 128);
      chk("wrap_conflicts", obs_c, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rs_cmd_gen
`default_nettype wire

// File: doc/rs_cmd_gen.md
Name: rs_cmd_gen

Overview:
- Upstream command stage for the rs flip-flop.
- Converts two raw, asynchronous push-button inputs into clean, mutually exclusive, single-cycle s/r command pulses: 2-flop synchronisation, counter debounce, rising-edge detection, then a small arbitration FSM.
- Guarantees the downstream flip-flop never sees s=1 and r=1 together; counts issued commands.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes (must be >= 1)
- CNT_W, 8, width of cmd_count

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- btn_set  input  1  raw set button, asynchronous to clk
- btn_reset  input  1  raw reset button, asynchronous to clk
- s  output  1  set command pulse to the flip-flop
- r  output  1  reset command pulse to the flip-flop
- conflict  output  1  one-cycle flag: a press was rejected because both buttons were active
- cmd_count  output  CNT_W  number of s/r pulses issued, wraps

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. While rst=1, all flops clear immediately:
  - sync regs, debounced levels, prev levels, counters = 0
  - state = IDLE
  - s = r = conflict = 0, cmd_count = 0
- Sync: per button, 2 flops; output sync2.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == db: count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: db <= sync2, count <= 0.
  - Else: count <= count+1.
  - Any mismatch break restarts the count.
- Edge detect: db_prev <= db each cycle; rise_x = db_x & ~db_prev_x (combinational).
- FSM states IDLE, WAIT_RELEASE. s, r and conflict are registered and default to 0 every cycle.
  - IDLE, rise_set & rise_reset: conflict <= 1; go WAIT_RELEASE.
  - IDLE, rise_set only:
    - if db_reset == 1: conflict <= 1.
    - else: s <= 1, cmd_count++.
    - go WAIT_RELEASE.
  - IDLE, rise_reset only: mirror of the above (r <= 1 or conflict <= 1); go WAIT_RELEASE.
  - IDLE, no rise: stay.
  - WAIT_RELEASE: no outputs. Rises are ignored, so a second button pressed while the first is held produces nothing. Go IDLE when db_set == 0 and db_reset == 0.
- Latency: btn stable high before edge E → db high after edge E+DEBOUNCE_CYCLES+1 → pulse high from edge E+DEBOUNCE_CYCLES+2 to E+DEBOUNCE_CYCLES+3. With default 4: pulse in the cycle after edge E+6, exactly 1 cycle wide.
- Invariants:
  - s & r never 1 together.
  - At most one of s, r, conflict high in any cycle.
  - One pulse per press regardless of hold length.
- cmd_count: increments on s or r issue only; 2^CNT_W-1 → 0 wrap; conflicts are not counted.
- Release is debounced identically; release glitches shorter than DEBOUNCE_CYCLES do not return the FSM to IDLE.
- Reset mid-operation: outputs drop asynchronously. If a button is still held after rst deasserts, it is re-debounced from db=0 and produces a new pulse.

Decomposition:
- Shared package/header rs_cmd_pkg:
  - state encodings (IDLE=1'b0, WAIT_RELEASE=1'b1)
  - default DEBOUNCE_CYCLES and CNT_W constants
- Sub-module btn_debounce (sync flops + stable counter + db register; ports clk, rst, btn_in, db_out), instantiated once per button.
- Edge detect, FSM and counter live in rs_cmd_gen.

Test Plan:
- btn_set high 3 cycles then low (DEBOUNCE_CYCLES=4) → no s, r or conflict; cmd_count stays 0.
- btn_set high from before edge E, held 20 cycles → s=1 only in the cycle after edge E+6; r=0 throughout; cmd_count=1; no second pulse while held.
- btn_set and btn_reset rise before the same edge, held 10 cycles → conflict one cycle after E+6; s=r=0; cmd_count unchanged. After both released ≥6 cycles, btn_reset alone → single r pulse; cmd_count=1.
- btn_set held and pulse issued, then btn_reset pressed while set held → no r, no conflict (WAIT_RELEASE). Release both, then btn_reset → r pulse.
- 256 alternating clean set/reset presses with CNT_W=8 → cmd_count returns to 0; s/r never overlap, checked by an assertion every cycle.
- rst asserted mid-edge of a pending pulse, between clock edges → s, cmd_count, state cleared without waiting for clk. btn_set still high after rst release → new s pulse DEBOUNCE_CYCLES+3 edges later.
